// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } div_mon_state_e;

  localparam int unsigned DefExpHigh = 6;
  localparam int unsigned DefExpLow  = 6;
  localparam int unsigned DefTol     = 0;

  // Largest value a cnt_w-bit width counter may hold before it sticks.
  function automatic int unsigned sat_limit(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// Samples the divided clock as data and produces registered rise/fall pulses.
// Define DIV_MON_SYNC_EN to insert a 2-flop synchroniser in front of the sample
// flop when the divided clock comes from another domain.
module div_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  logic w_d;
  logic r_s;
  logic r_s_q;
  logic r_rise_pulse;
  logic r_fall_pulse;

`ifdef DIV_MON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchroniser for an asynchronous divided clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign w_d = r_sync2;
`else
  assign w_d = i_d;
`endif

  // Sample, one-cycle history and registered edge pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s          <= 1'b0;
      r_s_q        <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_s          <= w_d;
      r_s_q        <= r_s;
      r_rise_pulse <= o_rise;
      r_fall_pulse <= o_fall;
    end
  end

  assign o_s          = r_s;
  assign o_rise       = r_s & ~r_s_q;
  assign o_fall       = ~r_s & r_s_q;
  assign o_rise_pulse = r_rise_pulse;
  assign o_fall_pulse = r_fall_pulse;

endmodule

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: edge pulses, high/low/period measurement and a sticky
// width-window error. Optional input synchroniser under DIV_MON_SYNC_EN.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_HIGH = DefExpHigh,
  parameter int unsigned EXP_LOW  = DefExpLow,
  parameter int unsigned TOL      = DefTol
) (
  input  logic             sys_clock,
  input  logic             sys_rst,
  input  logic             div_in,
  input  logic             meas_en,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             freq_err
);

  localparam logic [CNT_W-1:0] SatMax   = CNT_W'(sat_limit(CNT_W));
  localparam logic [CNT_W-1:0] SatPre   = CNT_W'(sat_limit(CNT_W) - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W:0]   ExpHighW = (CNT_W + 1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   ExpLowW  = (CNT_W + 1)'(EXP_LOW);
  localparam logic [CNT_W:0]   TolW     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W:0]   OneW     = (CNT_W + 1)'(1);

  div_mon_state_e   r_state;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_low_cnt;
  logic [CNT_W:0]   r_period;
  logic             r_meas_valid;
  logic             r_freq_err;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W:0]   w_dh;
  logic [CNT_W:0]   w_dl;
  logic [CNT_W:0]   w_dh_abs;
  logic [CNT_W:0]   w_dl_abs;
  logic             w_bad;
  logic             w_close;
  logic             w_sat_h;
  logic             w_sat_l;
  logic             w_err_set;

  div_edge_det u_edge (
    .i_clk        (sys_clock),
    .i_rst        (sys_rst),
    .i_d          (div_in),
    .o_s          (w_s),
    .o_rise       (w_rise),
    .o_fall       (w_fall),
    .o_rise_pulse (rise_pulse),
    .o_fall_pulse (fall_pulse)
  );

  // Two's-complement deviation at CNT_W+1 bits; top bit is the sign.
  assign w_dh     = {1'b0, r_hcnt} - ExpHighW;
  assign w_dl     = {1'b0, r_lcnt} - ExpLowW;
  assign w_dh_abs = w_dh[CNT_W] ? (~w_dh + OneW) : w_dh;
  assign w_dl_abs = w_dl[CNT_W] ? (~w_dl + OneW) : w_dl;
  assign w_bad    = (w_dh_abs > TolW) || (w_dl_abs > TolW);

  // A counter about to reach, or already at, its limit flags the error.
  assign w_close   = (r_state == StLow) && w_rise;
  assign w_sat_h   = (r_state == StHigh) && !w_fall && (r_hcnt >= SatPre);
  assign w_sat_l   = (r_state == StLow) && !w_rise && (r_lcnt >= SatPre);
  assign w_err_set = meas_en && (w_sat_h || w_sat_l || (w_close && w_bad));

  // Measurement FSM with width counters, result registers and sticky error.
  always_ff @(posedge sys_clock or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= StIdle;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_freq_err   <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_freq_err   <= w_err_set | (r_freq_err & ~err_clr);
      if (!meas_en) begin
        r_state <= StIdle;
        r_hcnt  <= '0;
        r_lcnt  <= '0;
      end else begin
        case (r_state)
          StIdle: r_state <= StArm;
          StArm: begin
            if (w_rise) begin
              r_state <= StHigh;
              r_hcnt  <= CntOne;
            end
          end
          StHigh: begin
            if (w_fall) begin
              r_state <= StLow;
              r_lcnt  <= CntOne;
            end else if (r_hcnt != SatMax) begin
              r_hcnt <= r_hcnt + CntOne;
            end
          end
          StLow: begin
            if (w_rise) begin
              r_high_cnt   <= r_hcnt;
              r_low_cnt    <= r_lcnt;
              r_period     <= {1'b0, r_hcnt} + {1'b0, r_lcnt};
              r_meas_valid <= 1'b1;
              r_state      <= StHigh;
              r_hcnt       <= CntOne;
              r_lcnt       <= '0;
            end else if (!w_s && (r_lcnt != SatMax)) begin
              r_lcnt <= r_lcnt + CntOne;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign high_cnt   = r_high_cnt;
  assign low_cnt    = r_low_cnt;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign freq_err   = r_freq_err;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Randomised bench for div_clk_monitor against a timestamp-based reference
// model. Two instances (TOL = 0 and TOL = 1) share the same stimulus.
module tb_div_clk_monitor;

  localparam int ExpH = 6;
  localparam int ExpL = 6;
  localparam int Sat  = 255;

  logic sys_clock = 1'b0;
  logic sys_rst;
  logic div_in;
  logic meas_en;
  logic err_clr;

  logic       a_rise, a_fall, a_valid, a_err;
  logic [7:0] a_h, a_l;
  logic [8:0] a_p;
  logic       b_rise, b_fall, b_valid, b_err;
  logic [7:0] b_h, b_l;
  logic [8:0] b_p;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edge index, last two samples, edge timestamps, last disarm.
  int   m_e;
  logic m_d1, m_d2;
  int   m_lr, m_lf, m_off;
  logic x_rise, x_fall, x_valid, x_err0, x_err1;
  int   x_h, x_l;

  always #5 sys_clock = ~sys_clock;

  div_clk_monitor #(.CNT_W(8), .EXP_HIGH(ExpH), .EXP_LOW(ExpL), .TOL(0)) u_dut_a (
    .sys_clock  (sys_clock),
    .sys_rst    (sys_rst),
    .div_in     (div_in),
    .meas_en    (meas_en),
    .err_clr    (err_clr),
    .rise_pulse (a_rise),
    .fall_pulse (a_fall),
    .high_cnt   (a_h),
    .low_cnt    (a_l),
    .period     (a_p),
    .meas_valid (a_valid),
    .freq_err   (a_err)
  );

  div_clk_monitor #(.CNT_W(8), .EXP_HIGH(ExpH), .EXP_LOW(ExpL), .TOL(1)) u_dut_b (
    .sys_clock  (sys_clock),
    .sys_rst    (sys_rst),
    .div_in     (div_in),
    .meas_en    (meas_en),
    .err_clr    (err_clr),
    .rise_pulse (b_rise),
    .fall_pulse (b_fall),
    .high_cnt   (b_h),
    .low_cnt    (b_l),
    .period     (b_p),
    .meas_valid (b_valid),
    .freq_err   (b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_d1    = 1'b0;
    m_d2    = 1'b0;
    m_lr    = -1;
    m_lf    = -1;
    m_off   = m_e;
    x_rise  = 1'b0;
    x_fall  = 1'b0;
    x_valid = 1'b0;
    x_err0  = 1'b0;
    x_err1  = 1'b0;
    x_h     = 0;
    x_l     = 0;
  endtask

  // A period closing at rise r2 counts when rise r1 < fall f < r2 and meas_en
  // was high at every edge from r1-1 through r2. Widths are edge distances.
  task automatic model_edge(input logic d, input logic en, input logic clr, input logic rst);
    logic rise, fall, set_sat, bad0, bad1;
    int   h, l;
    m_e++;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) m_off = m_e;
    rise    = m_d1 & ~m_d2;
    fall    = ~m_d1 & m_d2;
    x_rise  = rise;
    x_fall  = fall;
    x_valid = 1'b0;
    set_sat = 1'b0;
    bad0    = 1'b0;
    bad1    = 1'b0;
    if (rise) begin
      if (m_lr >= 0 && m_lf > m_lr && m_off < m_lr - 1) begin
        h       = (m_lf - m_lr > Sat) ? Sat : m_lf - m_lr;
        l       = (m_e - m_lf > Sat) ? Sat : m_e - m_lf;
        x_valid = 1'b1;
        x_h     = h;
        x_l     = l;
        bad0    = (iabs(h - ExpH) > 0) || (iabs(l - ExpL) > 0);
        bad1    = (iabs(h - ExpH) > 1) || (iabs(l - ExpL) > 1);
      end
      m_lr = m_e;
    end else if (fall) begin
      m_lf = m_e;
    end else if (m_lr >= 0 && m_off < m_lr - 1) begin
      if (m_d1 && m_lf < m_lr && m_e - m_lr >= Sat - 1) set_sat = 1'b1;
      if (!m_d1 && m_lf > m_lr && m_e - m_lf >= Sat - 1) set_sat = 1'b1;
    end
    x_err0 = set_sat | bad0 | (x_err0 & ~clr);
    x_err1 = set_sat | bad1 | (x_err1 & ~clr);
    m_d2   = m_d1;
    m_d1   = d;
  endtask

  task automatic compare_all();
    check_eq("a_rise", 32'(a_rise), 32'(x_rise));
    check_eq("a_fall", 32'(a_fall), 32'(x_fall));
    check_eq("a_valid", 32'(a_valid), 32'(x_valid));
    check_eq("a_high", 32'(a_h), 32'(x_h));
    check_eq("a_low", 32'(a_l), 32'(x_l));
    check_eq("a_period", 32'(a_p), 32'(x_h + x_l));
    check_eq("a_err", 32'(a_err), 32'(x_err0));
    check_eq("b_valid", 32'(b_valid), 32'(x_valid));
    check_eq("b_high", 32'(b_h), 32'(x_h));
    check_eq("b_period", 32'(b_p), 32'(x_h + x_l));
    check_eq("b_err", 32'(b_err), 32'(x_err1));
  endtask

  // Drive for one edge, update the model at the edge, compare just after it.
  task automatic tick(input logic d, input logic en, input logic clr);
    div_in  = d;
    meas_en = en;
    err_clr = clr;
    @(posedge sys_clock);
    model_edge(d, en, clr, sys_rst);
    #1;
    compare_all();
    @(negedge sys_clock);
  endtask

  task automatic seg(input logic lvl, input int len, input int drop_at, input logic clr);
    for (int i = 0; i < len; i++) tick(lvl, (i == drop_at) ? 1'b0 : 1'b1, clr);
  endtask

  task automatic square(input int hi, input int lo, input int n, input logic clr);
    for (int k = 0; k < n; k++) begin
      seg(1'b1, hi, -1, clr);
      seg(1'b0, lo, -1, clr);
    end
  endtask

  initial begin
    logic lvl;
    int   len;
    sys_rst = 1'b1;
    div_in  = 1'b0;
    meas_en = 1'b0;
    err_clr = 1'b0;
    m_e     = 0;
    model_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;

    // Nominal 6/6 wave, then short-high periods and a clear.
    seg(1'b0, 4, -1, 1'b0);
    square(6, 6, 5, 1'b0);
    square(5, 6, 3, 1'b0);
    square(6, 6, 2, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    square(6, 6, 2, 1'b0);

    // Stuck high long enough to saturate the high counter.
    seg(1'b1, 300, -1, 1'b0);
    square(0, 6, 1, 1'b0);
    square(6, 6, 2, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    seg(1'b0, 6, -1, 1'b0);

    // Single-cycle disarm in the middle of a high phase.
    square(6, 6, 2, 1'b0);
    seg(1'b1, 6, 2, 1'b0);
    seg(1'b0, 6, -1, 1'b0);
    square(6, 6, 3, 1'b0);

    // Clear held while failing periods complete: set must win.
    square(5, 6, 3, 1'b1);
    square(6, 6, 1, 1'b0);

    // Random widths with occasional disarm and clear.
    lvl = 1'b0;
    for (int k = 0; k < 60; k++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++)
        tick(lvl, ($urandom_range(0, 19) != 0), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a low phase.
    square(6, 6, 2, 1'b0);
    seg(1'b1, 6, -1, 1'b0);
    seg(1'b0, 3, -1, 1'b0);
    sys_rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    sys_rst = 1'b0;
    square(6, 6, 3, 1'b0);
    square(1, 1, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
